// File: rtl/os2ip_controller.sv
// rtl/os2ip_controller.sv - OS2IP sequencer: big-endian octet string to integer accumulator with valid/ready hand-off (optional length check: OS2IP_LEN_CHECK_EN)
module os2ip_controller #(
    parameter int DATA_BIT_WIDTH = 2048,
    parameter int CNT_WIDTH      = 9
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [7:0]                octet_in,
    input  logic                      octet_valid,
    input  logic                      last_octet,
    output logic                      octet_ready,
    output logic [DATA_BIT_WIDTH-1:0] int_out,
    output logic                      int_valid,
    input  logic                      int_ready,
    output logic [CNT_WIDTH-1:0]      octet_count,
    output logic                      busy
`ifdef OS2IP_LEN_CHECK_EN
    ,
    output logic                      len_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [DATA_BIT_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0]      r_count;
    logic                      w_accept;
    logic                      w_overlen;
    logic                      w_begin;

    // An octet is taken only while accumulating; ready is a pure state decode.
    assign w_accept = (r_state == S_ACCUM) && octet_valid;

`ifdef OS2IP_LEN_CHECK_EN
    localparam logic [CNT_WIDTH-1:0] C_MAX_OCTETS = CNT_WIDTH'(DATA_BIT_WIDTH / 8);
    logic r_len_err;

    // One octet past the integer width is an error; that octet is discarded.
    assign w_overlen = (r_count == C_MAX_OCTETS);
    // A new conversion may be launched from IDLE, or from ERR to recover.
    assign w_begin   = start && ((r_state == S_IDLE) || (r_state == S_ERR));
`else
    assign w_overlen = 1'b0;
    assign w_begin   = start && (r_state == S_IDLE);
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides every other event.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_next = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        if (w_overlen) begin
`ifdef OS2IP_LEN_CHECK_EN
                            w_next = S_ERR;
`else
                            w_next = S_IDLE;
`endif
                        end else if (last_octet) begin
                            w_next = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (int_ready) begin
                        w_next = S_IDLE;
                    end
                end
`ifdef OS2IP_LEN_CHECK_EN
                S_ERR: begin
                    if (start) begin
                        w_next = S_ACCUM;
                    end
                end
`endif
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Output decode from state only, so no input reaches an output combinationally.
    always_comb begin
        octet_ready = (r_state == S_ACCUM);
        int_valid   = (r_state == S_DONE);
        busy        = (r_state != S_IDLE);
    end

    // Accumulator and octet counter; result stays visible in IDLE until the next start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (abort || w_begin) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_accept && !w_overlen) begin
            r_acc <= {r_acc[DATA_BIT_WIDTH-9:0], octet_in};
            if (r_count != {CNT_WIDTH{1'b1}}) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

`ifdef OS2IP_LEN_CHECK_EN
    // Sticky length error: set on the overlength accept, cleared only by a new start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len_err <= 1'b0;
        end else if (abort) begin
            r_len_err <= r_len_err;
        end else if (w_begin) begin
            r_len_err <= 1'b0;
        end else if (w_accept && w_overlen) begin
            r_len_err <= 1'b1;
        end
    end

    assign len_err = r_len_err;
`endif

    assign int_out     = r_acc;
    assign octet_count = r_count;

endmodule

// File: tb/tb_os2ip_controller.sv
// tb/tb_os2ip_controller.sv - table-driven bench for os2ip_controller at 32-bit width
module tb_os2ip_controller;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [7:0]  octet_in;
    logic        octet_valid;
    logic        last_octet;
    logic        octet_ready;
    logic [31:0] int_out;
    logic        int_valid;
    logic        int_ready;
    logic [2:0]  octet_count;
    logic        busy;
`ifdef OS2IP_LEN_CHECK_EN
    logic        len_err;
`endif

    os2ip_controller #(
        .DATA_BIT_WIDTH(32),
        .CNT_WIDTH     (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .octet_in   (octet_in),
        .octet_valid(octet_valid),
        .last_octet (last_octet),
        .octet_ready(octet_ready),
        .int_out    (int_out),
        .int_valid  (int_valid),
        .int_ready  (int_ready),
        .octet_count(octet_count),
        .busy       (busy)
`ifdef OS2IP_LEN_CHECK_EN
        ,
        .len_err    (len_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        ab;
        logic [7:0]  oct;
        logic        ov;
        logic        lo;
        logic        ir;
        logic        e_rdy;
        logic        e_val;
        logic        e_busy;
        logic [2:0]  e_cnt;
        logic [31:0] e_out;
        logic        chk_le;
        logic        e_le;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic st, input logic ab, input logic [7:0] oct,
                       input logic ov, input logic lo, input logic ir,
                       input logic e_rdy, input logic e_val, input logic e_busy,
                       input logic [2:0] e_cnt, input logic [31:0] e_out,
                       input logic chk_le, input logic e_le);
        vec_t v;
        v.st = st; v.ab = ab; v.oct = oct; v.ov = ov; v.lo = lo; v.ir = ir;
        v.e_rdy = e_rdy; v.e_val = e_val; v.e_busy = e_busy;
        v.e_cnt = e_cnt; v.e_out = e_out; v.chk_le = chk_le; v.e_le = e_le;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic rdy, input logic val,
                           input logic bsy, input logic [2:0] cnt, input logic [31:0] out);
        chk("octet_ready", idx, {31'b0, octet_ready}, {31'b0, rdy});
        chk("int_valid",   idx, {31'b0, int_valid},   {31'b0, val});
        chk("busy",        idx, {31'b0, busy},        {31'b0, bsy});
        chk("octet_count", idx, {29'b0, octet_count}, {29'b0, cnt});
        chk("int_out",     idx, int_out, out);
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; octet_in = 8'h00; octet_valid = 0; last_octet = 0; int_ready = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();

        //  st ab oct    ov lo ir   rdy val bsy cnt out            chkle le
        // basic conversion
        add(1, 0, 8'h00, 0, 0, 0,   1, 0, 1, 3'd0, 32'h00000000, 0, 0);
        add(0, 0, 8'h01, 1, 0, 0,   1, 0, 1, 3'd1, 32'h00000001, 0, 0);
        add(0, 0, 8'h02, 1, 0, 0,   1, 0, 1, 3'd2, 32'h00000102, 0, 0);
        add(0, 0, 8'h03, 1, 0, 0,   1, 0, 1, 3'd3, 32'h00010203, 0, 0);
        add(0, 0, 8'h04, 1, 1, 0,   0, 1, 1, 3'd4, 32'h01020304, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 3'd4, 32'h01020304, 0, 0);
        // short string with backpressure
        add(1, 0, 8'h00, 0, 0, 0,   1, 0, 1, 3'd0, 32'h00000000, 0, 0);
        add(0, 0, 8'hAB, 1, 0, 0,   1, 0, 1, 3'd1, 32'h000000AB, 0, 0);
        add(0, 0, 8'hCD, 1, 1, 0,   0, 1, 1, 3'd2, 32'h0000ABCD, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 3'd2, 32'h0000ABCD, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 3'd2, 32'h0000ABCD, 0, 0);
        // gapped input, last_octet without valid ignored
        add(1, 0, 8'h00, 0, 0, 0,   1, 0, 1, 3'd0, 32'h00000000, 0, 0);
        add(0, 0, 8'hFF, 1, 0, 0,   1, 0, 1, 3'd1, 32'h000000FF, 0, 0);
        add(0, 0, 8'h55, 0, 0, 0,   1, 0, 1, 3'd1, 32'h000000FF, 0, 0);
        add(0, 0, 8'h66, 0, 1, 0,   1, 0, 1, 3'd1, 32'h000000FF, 0, 0);
        add(0, 0, 8'h10, 1, 1, 0,   0, 1, 1, 3'd2, 32'h0000FF10, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 3'd2, 32'h0000FF10, 0, 0);
        // abort mid-string, then a fresh one-octet conversion
        add(1, 0, 8'h00, 0, 0, 0,   1, 0, 1, 3'd0, 32'h00000000, 0, 0);
        add(0, 0, 8'h11, 1, 0, 0,   1, 0, 1, 3'd1, 32'h00000011, 0, 0);
        add(0, 0, 8'h22, 1, 0, 0,   1, 0, 1, 3'd2, 32'h00001122, 0, 0);
        add(0, 1, 8'h33, 1, 0, 0,   0, 0, 0, 3'd0, 32'h00000000, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0,   1, 0, 1, 3'd0, 32'h00000000, 0, 0);
        add(0, 0, 8'h7F, 1, 1, 0,   0, 1, 1, 3'd1, 32'h0000007F, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 3'd1, 32'h0000007F, 0, 0);
        // overlength string
        add(1, 0, 8'h00, 0, 0, 0,   1, 0, 1, 3'd0, 32'h00000000, 0, 0);
        add(0, 0, 8'h01, 1, 0, 0,   1, 0, 1, 3'd1, 32'h00000001, 0, 0);
        add(0, 0, 8'h02, 1, 0, 0,   1, 0, 1, 3'd2, 32'h00000102, 0, 0);
        add(0, 0, 8'h03, 1, 0, 0,   1, 0, 1, 3'd3, 32'h00010203, 0, 0);
        add(0, 0, 8'h04, 1, 0, 0,   1, 0, 1, 3'd4, 32'h01020304, 0, 0);
`ifdef OS2IP_LEN_CHECK_EN
        add(0, 0, 8'h05, 1, 1, 0,   0, 0, 1, 3'd4, 32'h01020304, 1, 1);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 1, 3'd4, 32'h01020304, 1, 1);
`else
        add(0, 0, 8'h05, 1, 1, 0,   0, 1, 1, 3'd5, 32'h02030405, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 3'd5, 32'h02030405, 0, 0);
`endif
        add(1, 0, 8'h00, 0, 0, 0,   1, 0, 1, 3'd0, 32'h00000000, 1, 0);
        add(0, 1, 8'h00, 0, 0, 0,   0, 0, 0, 3'd0, 32'h00000000, 0, 0);

        // reset values
        repeat (2) @(negedge clk);
        chk_all(-1, 0, 0, 0, 3'd0, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk_all(-2, 0, 0, 0, 3'd0, 32'h0);
`ifdef OS2IP_LEN_CHECK_EN
        chk("len_err_reset", -2, {31'b0, len_err}, 32'h0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            start       = vecs[i].st;
            abort       = vecs[i].ab;
            octet_in    = vecs[i].oct;
            octet_valid = vecs[i].ov;
            last_octet  = vecs[i].lo;
            int_ready   = vecs[i].ir;
            @(posedge clk);
            @(negedge clk);
            chk_all(i, vecs[i].e_rdy, vecs[i].e_val, vecs[i].e_busy, vecs[i].e_cnt, vecs[i].e_out);
`ifdef OS2IP_LEN_CHECK_EN
            if (vecs[i].chk_le)
                chk("len_err", i, {31'b0, len_err}, {31'b0, vecs[i].e_le});
`endif
        end
        idle_inputs();

        // asynchronous reset during ACCUM
        start = 1;
        @(posedge clk); @(negedge clk);
        start = 0; octet_valid = 1; octet_in = 8'hAA;
        @(posedge clk); @(negedge clk);
        octet_valid = 0;
        chk_all(100, 1, 0, 1, 3'd1, 32'h000000AA);
        reset_n = 1'b0;
        #1;
        chk_all(101, 0, 0, 0, 3'd0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_all(102, 0, 0, 0, 3'd0, 32'h0);

        // start while in DONE is ignored
        start = 1;
        @(posedge clk); @(negedge clk);
        start = 0; octet_valid = 1; last_octet = 1; octet_in = 8'h5A;
        @(posedge clk); @(negedge clk);
        octet_valid = 0; last_octet = 0;
        chk_all(103, 0, 1, 1, 3'd1, 32'h0000005A);
        start = 1;
        @(posedge clk); @(negedge clk);
        start = 0;
        chk_all(104, 0, 1, 1, 3'd1, 32'h0000005A);
        int_ready = 1;
        @(posedge clk); @(negedge clk);
        int_ready = 0;
        chk_all(105, 0, 0, 0, 3'd1, 32'h0000005A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
